// File: rtl/init_load_seq.sv
// Init-load sequencer: runs enabled channel loaders one at a time,
// retries failed channels, and muxes the active source read request.
module init_load_seq #(
    parameter int NCH       = 6,
    parameter int AW        = 25,
    parameter int LW        = 24,
    parameter int TMO_W     = 24,
    parameter int MAX_RETRY = 2
) (
    input  logic              sys_clk,
    input  logic              glbl_rst_n,
    input  logic              load_ram_en,
    input  logic [NCH-1:0]    ch_mask,
    output logic [NCH-1:0]    ch_en,
    input  logic [NCH-1:0]    ch_done,
    input  logic [NCH-1:0]    ch_error,
    input  logic [NCH-1:0]    ch_rden,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*LW-1:0] ch_length,
    output logic              init_rden,
    output logic [AW-1:0]     init_addr,
    output logic [LW-1:0]     init_length,
    output logic              load_ram_done,
    output logic              load_ram_error,
    output logic [NCH-1:0]    err_vec,
    output logic              busy
);

    localparam int IW = $clog2(NCH + 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        RUN,
        GAP,
        FINISH
    } state_t;

    state_t           state, state_d;
    logic [IW-1:0]    idx, idx_d;
    logic [2:0]       retry_cnt, retry_d;
    logic [TMO_W-1:0] timer, timer_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [NCH-1:0]   ch_en_d, err_d;
    logic             done_d, error_d, busy_d;
    logic             en_q;
    logic             rise, fall;

    logic [NCH-1:0]   sel_oh;
    logic             sel_mask, sel_done, sel_err, sel_rden;
    logic [AW-1:0]    sel_addr;
    logic [LW-1:0]    sel_len;

    // Decode the active index to one-hot and pick that channel's inputs
    always_comb begin
        sel_oh   = '0;
        sel_rden = 1'b0;
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (idx == IW'(i)) begin
                sel_oh[i] = 1'b1;
                sel_rden  = ch_rden[i];
                sel_addr  = ch_addr[i*AW +: AW];
                sel_len   = ch_length[i*LW +: LW];
            end
        end
    end

    assign sel_mask = |(mask_q & sel_oh);
    assign sel_done = |(ch_done & sel_oh);
    assign sel_err  = |(ch_error & sel_oh);
    assign rise     = load_ram_en & ~en_q;
    assign fall     = ~load_ram_en & en_q;

    // Next-state and next-output logic; abort outranks all channel events
    always_comb begin
        state_d = state;
        idx_d   = idx;
        retry_d = retry_cnt;
        timer_d = timer;
        mask_d  = mask_q;
        ch_en_d = ch_en;
        err_d   = err_vec;
        done_d  = load_ram_done;
        error_d = load_ram_error;
        busy_d  = busy;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    mask_d  = ch_mask;
                    err_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN, RUN, GAP: begin
                if (fall) begin
                    err_d   = err_vec | sel_oh;
                    ch_en_d = '0;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (state == SCAN) begin
                    if (idx == IW'(NCH)) begin
                        state_d = FINISH;
                    end else if (!sel_mask) begin
                        idx_d = idx + IW'(1);
                    end else begin
                        retry_d = '0;
                        timer_d = '0;
                        state_d = RUN;
                    end
                end else if (state == GAP) begin
                    timer_d = '0;
                    ch_en_d = sel_oh;
                    state_d = RUN;
                end else if (sel_err || (&timer)) begin
                    ch_en_d = '0;
                    if (retry_cnt < 3'(MAX_RETRY)) begin
                        retry_d = retry_cnt + 3'd1;
                        state_d = GAP;
                    end else begin
                        err_d   = err_vec | sel_oh;
                        idx_d   = idx + IW'(1);
                        state_d = SCAN;
                    end
                end else if (sel_done) begin
                    ch_en_d = '0;
                    idx_d   = idx + IW'(1);
                    state_d = SCAN;
                end else begin
                    ch_en_d = sel_oh;
                    timer_d = timer + TMO_W'(1);
                end
            end
            FINISH: begin
                done_d  = (err_vec == '0);
                error_d = (err_vec != '0);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequence state, bookkeeping and result registers
    always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
        if (!glbl_rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            retry_cnt      <= '0;
            timer          <= '0;
            mask_q         <= '0;
            ch_en          <= '0;
            err_vec        <= '0;
            load_ram_done  <= 1'b0;
            load_ram_error <= 1'b0;
            busy           <= 1'b0;
            en_q           <= 1'b0;
        end else begin
            state          <= state_d;
            idx            <= idx_d;
            retry_cnt      <= retry_d;
            timer          <= timer_d;
            mask_q         <= mask_d;
            ch_en          <= ch_en_d;
            err_vec        <= err_d;
            load_ram_done  <= done_d;
            load_ram_error <= error_d;
            busy           <= busy_d;
            en_q           <= load_ram_en;
        end
    end

    // Registered source read mux, only the running channel gets through
    always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
        if (!glbl_rst_n) begin
            init_rden   <= 1'b0;
            init_addr   <= '0;
            init_length <= '0;
        end else if (state == RUN) begin
            init_rden   <= sel_rden;
            init_addr   <= sel_addr;
            init_length <= sel_len;
        end else begin
            init_rden   <= 1'b0;
            init_addr   <= '0;
            init_length <= '0;
        end
    end

endmodule

// File: tb/tb_init_load_seq.sv
// Bench for init_load_seq: behavioural channel loaders plus
// scoreboards for the enable sequence and the read mux.
module tb_init_load_seq;

    localparam int NCH = 4;
    localparam int AW  = 25;
    localparam int LW  = 24;
    localparam logic [1:0] MD_SIL  = 2'd0;
    localparam logic [1:0] MD_DONE = 2'd1;
    localparam logic [1:0] MD_ERR  = 2'd2;

    typedef struct packed {
        logic          rden;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } rd_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_ram_en = 1'b0;
    logic [NCH-1:0]    ch_mask = '0;
    logic [NCH-1:0]    ch_done = '0;
    logic [NCH-1:0]    ch_error = '0;
    logic [NCH-1:0]    ch_rden = '0;
    logic [NCH*AW-1:0] ch_addr = '0;
    logic [NCH*LW-1:0] ch_length = '0;
    logic [NCH-1:0]    ch_en;
    logic [NCH-1:0]    err_vec;
    logic              init_rden;
    logic [AW-1:0]     init_addr;
    logic [LW-1:0]     init_length;
    logic              load_ram_done;
    logic              load_ram_error;
    logic              busy;

    int checks = 0;
    int failures = 0;

    logic [1:0]     mode [NCH];
    int             cnt [NCH];
    logic [NCH-1:0] en_q [$];
    int             dur_q [$];
    rd_t            rd_q [$];
    logic [NCH-1:0] prev_en = '0;
    int             hi_cnt = 0;
    int             low_cnt = 0;
    int             last_gap = 0;

    init_load_seq #(
        .NCH(NCH), .AW(AW), .LW(LW), .TMO_W(4), .MAX_RETRY(1)
    ) dut (
        .sys_clk       (clk),
        .glbl_rst_n    (rst_n),
        .load_ram_en   (load_ram_en),
        .ch_mask       (ch_mask),
        .ch_en         (ch_en),
        .ch_done       (ch_done),
        .ch_error      (ch_error),
        .ch_rden       (ch_rden),
        .ch_addr       (ch_addr),
        .ch_length     (ch_length),
        .init_rden     (init_rden),
        .init_addr     (init_addr),
        .init_length   (init_length),
        .load_ram_done (load_ram_done),
        .load_ram_error(load_ram_error),
        .err_vec       (err_vec),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {3'b0, ch_en, err_vec, busy, load_ram_done,
                load_ram_error, init_rden, init_addr, init_length};
    endfunction

    // Channel loaders: done 5 cycles after enable, error after 2, or silent
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            if (ch_en[i]) cnt[i]++;
            else cnt[i] = 0;
            ch_done[i]  = ch_en[i] && mode[i] == MD_DONE && cnt[i] == 5;
            ch_error[i] = ch_en[i] && mode[i] == MD_ERR && cnt[i] == 2;
        end
    end

    // Enable monitor: each new enable pops the expected one-hot
    initial forever begin
        @(negedge clk);
        if (ch_en != '0) begin
            if (prev_en == '0) begin
                last_gap = low_cnt;
                if (en_q.size() == 0) chk("en_extra", ch_en, 0);
                else chk("en_seq", ch_en, en_q.pop_front());
            end
            hi_cnt++;
            low_cnt = 0;
        end else begin
            if (prev_en != '0) dur_q.push_back(hi_cnt);
            hi_cnt = 0;
            low_cnt++;
        end
        prev_en = ch_en;
    end

    task automatic start(input logic [NCH-1:0] m);
        @(negedge clk);
        ch_mask = m;
        load_ram_en = 1'b1;
    endtask

    task automatic wait_idle(input int max, output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("seq_end", busy, 0);
    endtask

    task automatic wait_en(input logic [NCH-1:0] v, input int max);
        int n = 0;
        while (ch_en != v && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("wait_en", ch_en, v);
    endtask

    task automatic stop_en();
        @(negedge clk);
        load_ram_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_check();
        rd_t r;
        @(negedge clk);
        r = rd_q.pop_front();
        chk("rd_rden", init_rden, r.rden);
        chk("rd_addr", init_addr, r.addr);
        chk("rd_len", init_length, r.len);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NCH; i++) mode[i] = MD_SIL;

        #2 chk("rst_outs", outs(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst", outs(), 0);

        // read request while idle must not reach the output
        ch_rden = 4'b0001;
        ch_addr[0 +: AW] = 25'h0abc;
        rd_q.push_back({1'b0, 25'h0, 24'h0});
        rd_check();
        ch_rden = '0;
        ch_addr = '0;

        // mask 1011, every channel completes
        for (int i = 0; i < NCH; i++) mode[i] = MD_DONE;
        en_q.push_back(4'b0001);
        en_q.push_back(4'b0010);
        en_q.push_back(4'b1000);
        start(4'b1011);
        wait_idle(200, n);
        chk("m1011_done", load_ram_done, 1);
        chk("m1011_err", load_ram_error, 0);
        chk("m1011_vec", err_vec, 0);
        chk("m1011_left", en_q.size(), 0);
        stop_en();

        // empty mask walks all channels then finishes clean
        start(4'b0000);
        wait_idle(50, n);
        chk("zero_busy", n, NCH + 2);
        chk("zero_done", load_ram_done, 1);
        chk("zero_vec", err_vec, 0);
        stop_en();

        // ch0 fails twice with one cycle low between attempts
        mode[0] = MD_ERR;
        en_q.push_back(4'b0001);
        en_q.push_back(4'b0001);
        start(4'b0001);
        wait_idle(200, n);
        chk("err_gap", last_gap, 1);
        chk("err_vec", err_vec, 4'b0001);
        chk("err_flag", load_ram_error, 1);
        chk("err_done", load_ram_done, 0);
        chk("err_left", en_q.size(), 0);
        stop_en();

        // ch1 silent: two timeouts
        mode[1] = MD_SIL;
        dur_q.delete();
        en_q.push_back(4'b0010);
        en_q.push_back(4'b0010);
        start(4'b0010);
        wait_idle(200, n);
        chk("tmo_vec", err_vec, 4'b0010);
        chk("tmo_flag", load_ram_error, 1);
        chk("tmo_tries", dur_q.size(), 2);
        if (dur_q.size() > 0) chk("tmo_len", dur_q[0], 15);
        chk("tmo_left", en_q.size(), 0);
        stop_en();

        // read mux passes only the running channel
        mode[2] = MD_DONE;
        en_q.push_back(4'b0100);
        start(4'b0100);
        wait_en(4'b0100, 20);
        ch_rden = 4'b0101;
        ch_addr[2*AW +: AW] = 25'h1234;
        ch_length[2*LW +: LW] = 24'h55;
        ch_addr[0 +: AW] = 25'h0abc;
        ch_length[0 +: LW] = 24'h77;
        rd_q.push_back({1'b1, 25'h1234, 24'h55});
        rd_check();
        ch_rden = 4'b0001;
        ch_addr[2*AW +: AW] = '0;
        ch_length[2*LW +: LW] = '0;
        rd_q.push_back({1'b0, 25'h0, 24'h0});
        rd_check();
        ch_rden = '0;
        ch_addr = '0;
        ch_length = '0;
        wait_idle(100, n);
        chk("rd_seq_done", load_ram_done, 1);
        stop_en();

        // abort while ch1 runs
        mode[0] = MD_DONE;
        mode[1] = MD_SIL;
        en_q.push_back(4'b0001);
        en_q.push_back(4'b0010);
        start(4'b0011);
        wait_en(4'b0010, 50);
        load_ram_en = 1'b0;
        @(negedge clk);
        chk("abort_en", ch_en, 0);
        chk("abort_vec", err_vec, 4'b0010);
        chk("abort_err", load_ram_error, 1);
        chk("abort_done", load_ram_done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_left", en_q.size(), 0);
        @(negedge clk);

        // reset in the middle of a run
        en_q.push_back(4'b0010);
        start(4'b0010);
        wait_en(4'b0010, 50);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", outs(), 0);
        load_ram_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_result", outs(), 0);
        chk("rst_left", en_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/init_load_seq.md
INIT_LOAD_SEQ -- requirements
Module: init_load_seq

Interface
REQ-001 Parameter NCH, default 6, number of load channels (1..16).
REQ-002 Parameter AW, default 25, source read address width.
REQ-003 Parameter LW, default 24, source read length width.
REQ-004 Parameter TMO_W, default 24; per-attempt timeout counter width; timeout fires when the counter reaches all-ones.
REQ-005 Parameter MAX_RETRY, default 2; retries per channel after the first failed attempt (0..7).
REQ-006 sys_clk  in  1  sole clock; all logic is on its rising edge.
REQ-007 glbl_rst_n  in  1  asynchronous active-low reset.
REQ-008 load_ram_en  in  1  level request; a 0->1 edge starts a sequence; a 1->0 edge aborts it.
REQ-009 ch_mask  in  NCH  1 = channel participates; sampled on start only.
REQ-010 ch_en  out  NCH  one-hot enable to the channel loader being run.
REQ-011 ch_done / ch_error  in  NCH each  completion/failure from channel loaders.
REQ-012 ch_rden  in  NCH; ch_addr  in  NCH*AW; ch_length  in  NCH*LW  per-channel source read requests, channel i in slice i.
REQ-013 init_rden  out  1; init_addr  out  AW; init_length  out  LW  muxed source read request.
REQ-014 load_ram_done / load_ram_error  out  1 each  sequence result, level.
REQ-015 err_vec  out  NCH  channels that exhausted retries or were aborted.
REQ-016 busy  out  1  high from start until result is posted.

Function
REQ-017 FSM states: IDLE, SCAN, RUN, GAP, FINISH.
REQ-018 IDLE: on load_ram_en edge 0->1 (registered previous value): latch ch_mask; clear err_vec, load_ram_done, load_ram_error; ch_idx=0; go SCAN next cycle.
REQ-019 SCAN: if ch_idx==NCH go FINISH; if latched mask bit is 0, ch_idx+1 and stay in SCAN (one cycle per skipped channel); else retry_cnt=0, timer=0, go RUN.
REQ-020 RUN: ch_en[ch_idx]=1 registered; first asserted in the cycle after entering RUN; timer increments each cycle.
REQ-021 RUN, ch_done[ch_idx]=1 and ch_error[ch_idx]=0: ch_en low next cycle, ch_idx+1, go SCAN.
REQ-022 RUN, ch_error[ch_idx]=1 or timer all-ones: if retry_cnt<MAX_RETRY, retry_cnt+1 and go GAP; else set err_vec[ch_idx], ch_idx+1, go SCAN.
REQ-023 Simultaneous done and error on the active channel: error takes precedence.
REQ-024 done/error from non-active channels are ignored.
REQ-025 GAP: ch_en all zero for exactly 1 cycle, timer=0, then back to RUN (re-enable = restart of that channel).
REQ-026 FINISH: load_ram_done=1 if err_vec==0, else load_ram_error=1; busy=0; go IDLE; result held until next start or reset.
REQ-027 Read mux: in RUN only, init_rden/addr/length register ch_rden/addr/length of ch_idx; 1-cycle latency; all zeros in other states; other channels' requests are dropped.
REQ-028 Abort: load_ram_en 1->0 in SCAN/RUN/GAP sets err_vec[ch_idx] (if ch_idx<NCH), ch_en=0, load_ram_error=1, busy=0, go IDLE next cycle.
REQ-029 load_ram_en edge 0->1 while busy is ignored.
REQ-030 All-zero ch_mask: SCAN walks NCH cycles, FINISH sets load_ram_done=1.

Reset
REQ-031 glbl_rst_n=0 immediately forces IDLE and all outputs, ch_idx, retry_cnt, timer, latched mask and edge register to 0.
REQ-032 Reset mid-sequence discards all progress; no result is posted; a new 0->1 edge is needed after release.

Verification (NCH=4, TMO_W=4, MAX_RETRY=1)
REQ-033 mask=4'b1011, each enabled channel pulses done 5 cycles after ch_en -> ch_en sequence 0001,0010,1000; channel 2 never enabled; load_ram_done=1, err_vec=0.
REQ-034 mask=4'b0001, ch0 errors twice -> ch_en low 1 cycle between attempts; err_vec=4'b0001, load_ram_error=1.
REQ-035 mask=4'b0010, ch1 silent -> timeout after 15 cycles, retry, second timeout; err_vec=4'b0010.
REQ-036 ch2 active with rden=1, addr=0x1234; ch0 rden=1 simultaneously -> init_rden=1, init_addr=0x1234 one cycle later; ch0 request invisible.
REQ-037 Drop load_ram_en during ch1 RUN -> next cycle ch_en=0, err_vec=4'b0010, load_ram_error=1; assert glbl_rst_n=0 mid-RUN -> all outputs 0 asynchronously.
